dig_fx_enable_gen: RTL
======================

# dig_fx_enable_gen

Multi-channel, runtime-reconfigurable clock-enable synthesizer: the portable, vendor-independent successor to the fixed-ratio clock manager wrapper. From one input clock, each channel emits single-cycle enable pulses at an average rate of MULTIPLY/DIVIDE, generated by a phase accumulator. Each channel's ratio is reloaded through a valid/ready handshake, and each channel reports a per-channel lock status. It sits at the clock-generation edge of a design, driving enables for slower logic that shares `cin`.

## Interface
- `CHANNELS`, 2: number of independent enable channels (1–8).
- `RATIO_WIDTH`, 6: width of the multiply/divide values; legal values are 1..2^RATIO_WIDTH−1.
- `CLKFX_MULTIPLY`, 1: multiply value loaded into every channel at reset.
- `CLKFX_DIVIDE`, 2: divide value loaded into every channel at reset; must satisfy MULTIPLY ≤ DIVIDE.
- `LOCK_CYCLES`, 8: cycles after reset or reconfiguration before `locked` asserts (≥1).

Ports:
- `cin`  in  1  clock; the only clock.
- `rst`  in  1  synchronous, active-high reset.
- `cfg_valid`  in  1  configuration request.
- `cfg_ready`  out  1  block can accept a request.
- `cfg_ch`  in  3  target channel index.
- `cfg_mul`  in  RATIO_WIDTH  new multiply value M.
- `cfg_div`  in  RATIO_WIDTH  new divide value D.
- `cfg_err`  out  1  one-cycle pulse: the last accepted request was rejected.
- `cout`  out  CHANNELS  per-channel enable pulse, registered.
- `locked`  out  CHANNELS  per-channel ratio stable.
- `cfx`  out  CHANNELS  per-channel square wave; present only with the macro (see Configuration).

## Operation
- Each channel has:
  - accumulator `acc`, RATIO_WIDTH+1 bits;
  - M/D registers;
  - lock down-counter, $clog2(LOCK_CYCLES+1) bits.
- Every cycle, sum = acc + M, computed at RATIO_WIDTH+1 bits with no overflow because M ≤ D:
  - if sum ≥ D: acc ← sum − D and `cout[ch]` ← 1;
  - otherwise acc ← sum and `cout[ch]` ← 0.
- Result: exactly M pulses per D cycles, evenly spread. M = D gives `cout` high continuously.
- Lock counter: loaded with LOCK_CYCLES on reset or apply, then decrements to 0 and holds. `locked[ch]` = (counter == 0), registered.
- Configuration FSM has two states, IDLE and APPLY:
  - IDLE: `cfg_ready` = 1. On `cfg_valid && cfg_ready`, the request is latched and the FSM moves to APPLY.
  - APPLY: lasts one cycle with `cfg_ready` = 0, then returns to IDLE.
- Legality check in APPLY. A request is legal when all of the following hold: cfg_ch < CHANNELS, M ≥ 1, D ≥ 1, M ≤ D.
  - Legal request: target channel gets M/D ← new values, acc ← 0, `cout` ← 0, lock counter ← LOCK_CYCLES, `locked` ← 0. Other channels are undisturbed.
  - Illegal request: `cfg_err` pulses for one cycle and no state changes.
- Re-applying the current ratio to a channel still restarts its phase and drops its lock.

## Timing
- Reset values (the edge where `rst` is high):
  - acc = 0, M/D = CLKFX_MULTIPLY/CLKFX_DIVIDE, lock counter = LOCK_CYCLES;
  - outputs: `cout` = 0, `locked` = 0, `cfg_err` = 0, `cfg_ready` = 0, `cfx` = 0;
  - FSM enters IDLE.
- Cycle numbering: edge 1 is the first rising edge with `rst` low.
- Lock timing: `cfg_ready` = 1 from edge 1. `locked` rises at edge LOCK_CYCLES+1.
- Pulse latency: with M = 1, D = 2, `cout` first goes high after edge 2, then after every second edge. In general, the first pulse follows edge ceil(D/M).
- Handshake accepted at edge t:
  - APPLY occupies edge t+1;
  - new-ratio accumulation starts at edge t+2;
  - `cfg_err` (if the request is illegal) is high between edge t+1 and edge t+2;
  - `cfg_ready` returns high after edge t+1.
- `cfg_valid` held high continuously: requests are accepted every second cycle.
- `rst` asserted mid-APPLY aborts the pending request; it is never applied.

## Configuration
- `DIG_FXGEN_CFX_EN` defined:
  - `cfx` port exists;
  - `cfx[ch]` toggles on every cycle where `cout[ch]` = 1, giving a frequency of M/(2D) of `cin`;
  - `cfx[ch]` resets to 0 and clears to 0 on apply.
- Not defined: no `cfx` port and no toggle flops. All other behaviour is identical.

## Structure
- Package `dig_fxgen_pkg`:
  - FSM state enum (IDLE, APPLY);
  - ratio typedef parameterised by RATIO_WIDTH;
  - a function `ratio_legal(m, d)`.
- Sub-module `dig_fxgen_channel`: one channel's accumulator, M/D registers, lock counter and optional `cfx` toggle, with a load strobe. The top instantiates CHANNELS copies and the shared configuration FSM.

## Test plan
- Reset defaults, M = 1, D = 2: `cout` pulses after edges 2, 4, 6…; `locked` rises at edge 9; `cfg_ready` = 1 from edge 1.
- Configure ch1 to M = 3, D = 7: over 70 cycles, exactly 30 pulses with no two consecutive; ch0 pulse pattern is unchanged; `locked[1]` is low for 8 cycles after APPLY, then high.
- Illegal requests (M = 5, D = 4), (D = 0) and (cfg_ch = 2 with CHANNELS = 2): each gives a one-cycle `cfg_err`; all ratios and `locked` are unchanged.
- M = D = 7: `cout` is held at 1 every cycle from edge 1; `cfx` (macro on) toggles every cycle.
- `cfg_valid` held high with alternating legal configurations: accepts occur every 2 cycles and `cfg_ready` shows the 1,0 pattern.
- `rst` asserted the cycle after a handshake: the request is not applied, and all channels return to the reset ratio and the reset `locked` timing.

Source files
------------

// File: rtl/dig_fxgen_pkg.sv
// Shared types and helpers for the dig_fx_enable_gen clock-enable synthesizer.
package dig_fxgen_pkg;

    // Widest ratio the legality helper handles; channel ratios are zero-extended into it.
    localparam int RATIO_WIDTH_MAX = 16;

    typedef enum logic {
        IDLE  = 1'b0,
        APPLY = 1'b1
    } fsm_state_t;

    typedef logic [RATIO_WIDTH_MAX-1:0] ratio_t;

    function automatic logic ratio_legal(input ratio_t m, input ratio_t d);
        return (m != '0) && (d != '0) && (m <= d);
    endfunction

endpackage

// File: rtl/dig_fxgen_channel.sv
// One enable channel: phase accumulator, M/D registers, lock counter and,
// when DIG_FXGEN_CFX_EN is defined, a square-wave toggle flop.
module dig_fxgen_channel
    import dig_fxgen_pkg::*;
#(
    parameter int RATIO_WIDTH    = 6,
    parameter int CLKFX_MULTIPLY = 1,
    parameter int CLKFX_DIVIDE   = 2,
    parameter int LOCK_CYCLES    = 8
) (
    input  logic                   cin,
    input  logic                   rst,
    input  logic                   load,
    input  logic [RATIO_WIDTH-1:0] load_mul,
    input  logic [RATIO_WIDTH-1:0] load_div,
    output logic                   cout,
`ifdef DIG_FXGEN_CFX_EN
    output logic                   cfx,
`endif
    output logic                   locked
);

    localparam int CNT_W = $clog2(LOCK_CYCLES + 1);

    logic [RATIO_WIDTH:0]   acc;
    logic [RATIO_WIDTH:0]   sum;
    logic [RATIO_WIDTH-1:0] mul_q;
    logic [RATIO_WIDTH-1:0] div_q;
    logic [CNT_W-1:0]       lock_cnt;

    // acc < D and M <= D keep the sum below 2*D, so one extra bit is enough.
    always_comb begin
        sum = acc + {1'b0, mul_q};
    end

    always_ff @(posedge cin) begin
        if (rst) begin
            acc      <= '0;
            mul_q    <= RATIO_WIDTH'(CLKFX_MULTIPLY);
            div_q    <= RATIO_WIDTH'(CLKFX_DIVIDE);
            cout     <= 1'b0;
            lock_cnt <= CNT_W'(LOCK_CYCLES);
            locked   <= 1'b0;
        end else if (load) begin
            acc      <= '0;
            mul_q    <= load_mul;
            div_q    <= load_div;
            cout     <= 1'b0;
            lock_cnt <= CNT_W'(LOCK_CYCLES);
            locked   <= 1'b0;
        end else begin
            if (sum >= {1'b0, div_q}) begin
                acc  <= sum - {1'b0, div_q};
                cout <= 1'b1;
            end else begin
                acc  <= sum;
                cout <= 1'b0;
            end
            if (lock_cnt != '0) begin
                lock_cnt <= lock_cnt - 1'b1;
            end
            locked <= (lock_cnt == '0);
        end
    end

`ifdef DIG_FXGEN_CFX_EN
    always_ff @(posedge cin) begin
        if (rst || load) begin
            cfx <= 1'b0;
        end else begin
            cfx <= cfx ^ cout;
        end
    end
`endif

endmodule

// File: rtl/dig_fx_enable_gen.sv
// Multi-channel M/D clock-enable synthesizer with a valid/ready ratio reload port.
// Optional per-channel square-wave output enabled by DIG_FXGEN_CFX_EN.
module dig_fx_enable_gen
    import dig_fxgen_pkg::*;
#(
    parameter int CHANNELS       = 2,
    parameter int RATIO_WIDTH    = 6,
    parameter int CLKFX_MULTIPLY = 1,
    parameter int CLKFX_DIVIDE   = 2,
    parameter int LOCK_CYCLES    = 8
) (
    input  logic                   cin,
    input  logic                   rst,
    input  logic                   cfg_valid,
    output logic                   cfg_ready,
    input  logic [2:0]             cfg_ch,
    input  logic [RATIO_WIDTH-1:0] cfg_mul,
    input  logic [RATIO_WIDTH-1:0] cfg_div,
    output logic                   cfg_err,
    output logic [CHANNELS-1:0]    cout,
`ifdef DIG_FXGEN_CFX_EN
    output logic [CHANNELS-1:0]    cfx,
`endif
    output logic [CHANNELS-1:0]    locked
);

    // Handshake: a request transfers on a rising edge where cfg_valid && cfg_ready;
    // the payload is sampled on that edge only and ready then drops for the APPLY cycle.
    fsm_state_t             state;
    fsm_state_t             state_next;
    logic                   accept;
    logic                   apply_ok;
    logic                   ready_q;
    logic                   err_q;
    logic [2:0]             req_ch;
    logic [RATIO_WIDTH-1:0] req_mul;
    logic [RATIO_WIDTH-1:0] req_div;
    logic                   req_legal;
    logic [CHANNELS-1:0]    load;

    assign cfg_ready = ready_q;
    assign cfg_err   = err_q;
    assign req_legal = (32'(req_ch) < 32'(CHANNELS))
                    && ratio_legal(ratio_t'(req_mul), ratio_t'(req_div));

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        apply_ok   = 1'b0;
        case (state)
            IDLE: begin
                if (cfg_valid && cfg_ready) begin
                    accept     = 1'b1;
                    state_next = APPLY;
                end
            end
            APPLY: begin
                apply_ok   = req_legal;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge cin) begin
        if (rst) begin
            state   <= IDLE;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            req_ch  <= '0;
            req_mul <= '0;
            req_div <= '0;
        end else begin
            state   <= state_next;
            ready_q <= (state_next == IDLE);
            err_q   <= (state == APPLY) && !apply_ok;
            if (accept) begin
                req_ch  <= cfg_ch;
                req_mul <= cfg_mul;
                req_div <= cfg_div;
            end
        end
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        assign load[i] = apply_ok && (req_ch == 3'(i));

        dig_fxgen_channel #(
            .RATIO_WIDTH    (RATIO_WIDTH),
            .CLKFX_MULTIPLY (CLKFX_MULTIPLY),
            .CLKFX_DIVIDE   (CLKFX_DIVIDE),
            .LOCK_CYCLES    (LOCK_CYCLES)
        ) u_channel (
            .cin      (cin),
            .rst      (rst),
            .load     (load[i]),
            .load_mul (req_mul),
            .load_div (req_div),
            .cout     (cout[i]),
`ifdef DIG_FXGEN_CFX_EN
            .cfx      (cfx[i]),
`endif
            .locked   (locked[i])
        );
    end

endmodule
